// File: rtl/bypass_select_ctrl.sv
// Purpose : operand bypass scheduler; tracks in-flight producers and selects bypass (stage, lane) per consumer operand. Optional macro RSD_BYPASS_MULTI_MATCH_CHECK_EN adds multi_match output + sim check.
// Latency : 1 cycle, RR inputs to registered select, which lines up with the consumer's EX cycle.
// Backpressure: stall holds all tracking state and outputs (inputs ignored); flush clears all valids and overrides stall.
module bypass_select_ctrl #(
    parameter int INT_LANES  = 2,
    parameter int MEM_LANES  = 2,
    parameter int CONS_LANES = 2,
    parameter int PREG_W     = 7,
    parameter int LANE_W     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [INT_LANES-1:0]         int_rr_valid,
    input  logic [INT_LANES*PREG_W-1:0]  int_rr_dst,
    input  logic [MEM_LANES-1:0]         mem_ex_valid,
    input  logic [MEM_LANES*PREG_W-1:0]  mem_ex_dst,
    input  logic [CONS_LANES-1:0]        cons_valid,
    input  logic [CONS_LANES*PREG_W-1:0] cons_srcA,
    input  logic [CONS_LANES*PREG_W-1:0] cons_srcB,
    input  logic [CONS_LANES-1:0]        cons_readA,
    input  logic [CONS_LANES-1:0]        cons_readB,
    output logic [CONS_LANES-1:0]        selA_valid,
    output logic [CONS_LANES*2-1:0]      selA_stg,
    output logic [CONS_LANES*LANE_W-1:0] selA_lane,
    output logic [CONS_LANES-1:0]        selB_valid,
    output logic [CONS_LANES*2-1:0]      selB_stg,
    output logic [CONS_LANES*LANE_W-1:0] selB_lane
`ifdef RSD_BYPASS_MULTI_MATCH_CHECK_EN
    ,
    output logic                         multi_match
`endif
);

    localparam logic [1:0] STG_INT_EX = 2'd0;
    localparam logic [1:0] STG_INT_WB = 2'd1;
    localparam logic [1:0] STG_MEM_MA = 2'd2;
    localparam logic [1:0] STG_MEM_WB = 2'd3;

    // Candidate producers, flattened in priority order:
    // int_rr lanes, int_ex lanes, mem_ex lanes, mem_ma lanes.
    localparam int NCAND = 2*INT_LANES + 2*MEM_LANES;

    typedef struct packed {
        logic              vld;
        logic [1:0]        stg;
        logic [LANE_W-1:0] lane;
    } sel_t;

    // Producers one stage past RR/EX. A producer in intEx/memMa at cycle t is
    // in WB at t+1, which is the last bypassable point, so the WB-stage copies
    // carry no further bypass information and are not stored.
    logic [INT_LANES-1:0]        int_ex_valid;
    logic [INT_LANES*PREG_W-1:0] int_ex_dst;
    logic [MEM_LANES-1:0]        mem_ma_valid;
    logic [MEM_LANES*PREG_W-1:0] mem_ma_dst;

    logic [NCAND-1:0]  cand_v;
    logic [PREG_W-1:0] cand_d [NCAND];
    logic [NCAND-1:0]  hit_a  [CONS_LANES];
    logic [NCAND-1:0]  hit_b  [CONS_LANES];
    sel_t              sel_a_nxt [CONS_LANES];
    sel_t              sel_b_nxt [CONS_LANES];
    sel_t              sel_a_q   [CONS_LANES];
    sel_t              sel_b_q   [CONS_LANES];

    function automatic logic [1:0] stg_of(input int k);
        if (k < INT_LANES)                      return STG_INT_EX;
        else if (k < 2*INT_LANES)               return STG_INT_WB;
        else if (k < 2*INT_LANES + MEM_LANES)   return STG_MEM_MA;
        else                                    return STG_MEM_WB;
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input int k);
        int l;
        if (k < INT_LANES)                      l = k;
        else if (k < 2*INT_LANES)               l = k - INT_LANES;
        else if (k < 2*INT_LANES + MEM_LANES)   l = k - 2*INT_LANES;
        else                                    l = k - 2*INT_LANES - MEM_LANES;
        return LANE_W'(l);
    endfunction

    // Lowest candidate index wins: scan from the back so the front overwrites.
    function automatic sel_t pick(input logic [NCAND-1:0] hit);
        sel_t r;
        r = '0;
        for (int k = NCAND-1; k >= 0; k--) begin
            if (hit[k]) begin
                r.vld  = 1'b1;
                r.stg  = stg_of(k);
                r.lane = lane_of(k);
            end
        end
        return r;
    endfunction

    // Gather the candidate list in priority order.
    always_comb begin
        cand_v = '0;
        for (int k = 0; k < NCAND; k++) cand_d[k] = '0;
        for (int i = 0; i < INT_LANES; i++) begin
            cand_v[i]             = int_rr_valid[i];
            cand_d[i]             = int_rr_dst[i*PREG_W +: PREG_W];
            cand_v[INT_LANES + i] = int_ex_valid[i];
            cand_d[INT_LANES + i] = int_ex_dst[i*PREG_W +: PREG_W];
        end
        for (int j = 0; j < MEM_LANES; j++) begin
            cand_v[2*INT_LANES + j]             = mem_ex_valid[j];
            cand_d[2*INT_LANES + j]             = mem_ex_dst[j*PREG_W +: PREG_W];
            cand_v[2*INT_LANES + MEM_LANES + j] = mem_ma_valid[j];
            cand_d[2*INT_LANES + MEM_LANES + j] = mem_ma_dst[j*PREG_W +: PREG_W];
        end
    end

    // Tag compare every operand against every candidate, then prioritise.
    always_comb begin
        for (int c = 0; c < CONS_LANES; c++) begin
            hit_a[c] = '0;
            hit_b[c] = '0;
            for (int k = 0; k < NCAND; k++) begin
                hit_a[c][k] = cand_v[k] && cons_valid[c] && cons_readA[c] &&
                              (cand_d[k] == cons_srcA[c*PREG_W +: PREG_W]);
                hit_b[c][k] = cand_v[k] && cons_valid[c] && cons_readB[c] &&
                              (cand_d[k] == cons_srcB[c*PREG_W +: PREG_W]);
            end
            sel_a_nxt[c] = pick(hit_a[c]);
            sel_b_nxt[c] = pick(hit_b[c]);
        end
    end

    // Producer tracking and registered selects; flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ex_valid <= '0;
            int_ex_dst   <= '0;
            mem_ma_valid <= '0;
            mem_ma_dst   <= '0;
            for (int c = 0; c < CONS_LANES; c++) begin
                sel_a_q[c] <= '0;
                sel_b_q[c] <= '0;
            end
        end else if (flush) begin
            int_ex_valid <= '0;
            mem_ma_valid <= '0;
            for (int c = 0; c < CONS_LANES; c++) begin
                sel_a_q[c] <= '0;
                sel_b_q[c] <= '0;
            end
        end else if (!stall) begin
            int_ex_valid <= int_rr_valid;
            int_ex_dst   <= int_rr_dst;
            mem_ma_valid <= mem_ex_valid;
            mem_ma_dst   <= mem_ex_dst;
            for (int c = 0; c < CONS_LANES; c++) begin
                sel_a_q[c] <= sel_a_nxt[c];
                sel_b_q[c] <= sel_b_nxt[c];
            end
        end
    end

    // Unpack registered selects onto the flat output buses.
    always_comb begin
        for (int c = 0; c < CONS_LANES; c++) begin
            selA_valid[c]                 = sel_a_q[c].vld;
            selA_stg[c*2 +: 2]            = sel_a_q[c].stg;
            selA_lane[c*LANE_W +: LANE_W] = sel_a_q[c].lane;
            selB_valid[c]                 = sel_b_q[c].vld;
            selB_stg[c*2 +: 2]            = sel_b_q[c].stg;
            selB_lane[c*LANE_W +: LANE_W] = sel_b_q[c].lane;
        end
    end

`ifdef RSD_BYPASS_MULTI_MATCH_CHECK_EN
    logic multi_nxt;

    // More than one hit on any operand: clear-lowest-bit test per operand.
    always_comb begin
        multi_nxt = 1'b0;
        for (int c = 0; c < CONS_LANES; c++) begin
            if ((hit_a[c] & (hit_a[c] - 1'b1)) != '0) multi_nxt = 1'b1;
            if ((hit_b[c] & (hit_b[c] - 1'b1)) != '0) multi_nxt = 1'b1;
        end
    end

    // Multi-match flag follows the same hold/clear rules as the selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      multi_match <= 1'b0;
        else if (flush)  multi_match <= 1'b0;
        else if (!stall) multi_match <= multi_nxt;
    end

    // Flag ambiguous producer tags in simulation.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && !stall)
            assert (!multi_nxt) else $warning("bypass_select_ctrl: operand matched multiple producers");
    end
`endif

endmodule

// File: tb/tb_bypass_select_ctrl.sv
// Purpose : directed self-checking bench for bypass_select_ctrl.
// Latency : checks sampled 1 ns after each rising edge.
// Backpressure: exercises stall hold and flush-over-stall.
module tb_bypass_select_ctrl;

    localparam int INT_LANES  = 2;
    localparam int MEM_LANES  = 2;
    localparam int CONS_LANES = 2;
    localparam int PREG_W     = 7;
    localparam int LANE_W     = 1;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         stall;
    logic                         flush;
    logic [INT_LANES-1:0]         int_rr_valid;
    logic [INT_LANES*PREG_W-1:0]  int_rr_dst;
    logic [MEM_LANES-1:0]         mem_ex_valid;
    logic [MEM_LANES*PREG_W-1:0]  mem_ex_dst;
    logic [CONS_LANES-1:0]        cons_valid;
    logic [CONS_LANES*PREG_W-1:0] cons_srcA;
    logic [CONS_LANES*PREG_W-1:0] cons_srcB;
    logic [CONS_LANES-1:0]        cons_readA;
    logic [CONS_LANES-1:0]        cons_readB;
    logic [CONS_LANES-1:0]        selA_valid;
    logic [CONS_LANES*2-1:0]      selA_stg;
    logic [CONS_LANES*LANE_W-1:0] selA_lane;
    logic [CONS_LANES-1:0]        selB_valid;
    logic [CONS_LANES*2-1:0]      selB_stg;
    logic [CONS_LANES*LANE_W-1:0] selB_lane;
`ifdef RSD_BYPASS_MULTI_MATCH_CHECK_EN
    logic                         multi_match;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    bypass_select_ctrl #(
        .INT_LANES(INT_LANES), .MEM_LANES(MEM_LANES), .CONS_LANES(CONS_LANES),
        .PREG_W(PREG_W), .LANE_W(LANE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .int_rr_valid(int_rr_valid), .int_rr_dst(int_rr_dst),
        .mem_ex_valid(mem_ex_valid), .mem_ex_dst(mem_ex_dst),
        .cons_valid(cons_valid), .cons_srcA(cons_srcA), .cons_srcB(cons_srcB),
        .cons_readA(cons_readA), .cons_readB(cons_readB),
        .selA_valid(selA_valid), .selA_stg(selA_stg), .selA_lane(selA_lane),
        .selB_valid(selB_valid), .selB_stg(selB_stg), .selB_lane(selB_lane)
`ifdef RSD_BYPASS_MULTI_MATCH_CHECK_EN
        , .multi_match(multi_match)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected packing: {valid, stg[1:0], lane}
    task automatic chk_a(input string tag, input int c, input logic [3:0] exp);
        chk(tag, {28'd0, selA_valid[c], selA_stg[c*2 +: 2], selA_lane[c*LANE_W +: LANE_W]}, {28'd0, exp});
    endtask

    task automatic chk_b(input string tag, input int c, input logic [3:0] exp);
        chk(tag, {28'd0, selB_valid[c], selB_stg[c*2 +: 2], selB_lane[c*LANE_W +: LANE_W]}, {28'd0, exp});
    endtask

    task automatic clr;
        stall = 1'b0; flush = 1'b0;
        int_rr_valid = '0; int_rr_dst = '0;
        mem_ex_valid = '0; mem_ex_dst = '0;
        cons_valid = '0; cons_srcA = '0; cons_srcB = '0;
        cons_readA = '0; cons_readB = '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) tick();
        chk("rst_selA_valid", {30'd0, selA_valid}, 32'd0);
        chk("rst_selA_stg",   {28'd0, selA_stg},   32'd0);
        chk("rst_selB_valid", {30'd0, selB_valid}, 32'd0);
        chk("rst_selB_lane",  {30'd0, selB_lane},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back int: EX then WB then gone
        clr();
        int_rr_valid = 2'b10; int_rr_dst[13:7] = 7'd5;
        cons_valid[0] = 1'b1; cons_srcA[6:0] = 7'd5; cons_readA[0] = 1'b1;
        tick();
        chk_a("b2b_int_ex", 0, 4'b1001);
        chk_b("b2b_b_unread", 0, 4'b0000);
        int_rr_valid = '0;
        tick();
        chk_a("b2b_int_wb", 0, 4'b1011);
        tick();
        chk_a("b2b_retired", 0, 4'b0000);

        // Load chain: same cycle -> MEM_MA, next cycle -> MEM_WB
        clr();
        mem_ex_valid = 2'b01; mem_ex_dst[6:0] = 7'd9;
        cons_valid[1] = 1'b1; cons_srcB[13:7] = 7'd9; cons_readB[1] = 1'b1;
        tick();
        chk_b("load_mem_ma", 1, 4'b1100);
        mem_ex_valid = '0;
        tick();
        chk_b("load_mem_wb", 1, 4'b1110);

        // Priority: INT_EX lane0 beats MEM_MA lane1; A and B both select
        clr();
        int_rr_valid = 2'b01; int_rr_dst[6:0] = 7'd12;
        mem_ex_valid = 2'b10; mem_ex_dst[13:7] = 7'd12;
        cons_valid[0] = 1'b1; cons_srcA[6:0] = 7'd12; cons_readA[0] = 1'b1;
        cons_srcB[6:0] = 7'd12; cons_readB[0] = 1'b1;
        tick();
        chk_a("prio_int_ex_a", 0, 4'b1000);
        chk_b("prio_int_ex_b", 0, 4'b1000);
`ifdef RSD_BYPASS_MULTI_MATCH_CHECK_EN
        chk("prio_multi_match", {31'd0, multi_match}, 32'd1);
`endif

        // Lowest lane wins, then INT_WB over MEM_MA, then MEM_WB lane1
        clr();
        int_rr_valid = 2'b11; int_rr_dst = {7'd20, 7'd20};
        cons_valid[1] = 1'b1; cons_srcA[13:7] = 7'd20; cons_readA[1] = 1'b1;
        tick();
        chk_a("prio_low_lane", 1, 4'b1000);
        int_rr_valid = '0;
        mem_ex_valid = 2'b10; mem_ex_dst[13:7] = 7'd20;
        tick();
        chk_a("prio_wb_over_ma", 1, 4'b1010);
        mem_ex_valid = '0;
        tick();
        chk_a("prio_mem_wb_l1", 1, 4'b1111);

        // Stall: select held, ignored inputs, then INT_WB
        clr();
        tick();
        int_rr_valid = 2'b01; int_rr_dst[6:0] = 7'd3;
        cons_valid[0] = 1'b1; cons_srcA[6:0] = 7'd3; cons_readA[0] = 1'b1;
        tick();
        chk_a("stall_pre", 0, 4'b1000);
        stall = 1'b1;
        int_rr_valid = 2'b10; int_rr_dst = {7'd3, 7'd0};
        tick();
        chk_a("stall_hold1", 0, 4'b1000);
        tick();
        tick();
        chk_a("stall_hold3", 0, 4'b1000);
        stall = 1'b0; int_rr_valid = '0; int_rr_dst = '0;
        tick();
        chk_a("stall_then_wb", 0, 4'b1010);

        // Flush during stall: clears select and tracked producer
        clr();
        tick();
        int_rr_valid = 2'b01; int_rr_dst[6:0] = 7'd3;
        cons_valid[0] = 1'b1; cons_srcA[6:0] = 7'd3; cons_readA[0] = 1'b1;
        tick();
        chk_a("flush_pre", 0, 4'b1000);
        stall = 1'b1;
        tick();
        flush = 1'b1;
        int_rr_valid = 2'b10; int_rr_dst = {7'd3, 7'd3};
        tick();
        chk_a("flush_clears_sel", 0, 4'b0000);
        flush = 1'b0; stall = 1'b0; int_rr_valid = '0;
        tick();
        chk_a("flush_no_bypass", 0, 4'b0000);

        // Asynchronous reset while a select is valid
        clr();
        int_rr_valid = 2'b01; int_rr_dst[6:0] = 7'd7;
        cons_valid[0] = 1'b1; cons_srcA[6:0] = 7'd7; cons_readA[0] = 1'b1;
        tick();
        chk_a("areset_pre", 0, 4'b1000);
        int_rr_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("areset_immediate", 0, 4'b0000);
        chk("areset_all_valid", {28'd0, selA_valid, selB_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_a("areset_no_stale", 0, 4'b0000);

        // Read gating: readB=0 or cons_valid=0 blocks the select
        clr();
        int_rr_valid = 2'b01; int_rr_dst[6:0] = 7'd30;
        cons_valid = 2'b01;
        cons_srcA[6:0] = 7'd30; cons_readA[0] = 1'b1;
        cons_srcB = {7'd30, 7'd30}; cons_readB = 2'b10;
        tick();
        chk_a("gate_control_a", 0, 4'b1000);
        chk_b("gate_readb0", 0, 4'b0000);
        chk_b("gate_consvalid0", 1, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
